// File: rtl/ws2811_frame_sequencer_if.sv
// Sequencer-side bundle: tick/IR command inputs, pattern ROM port and WS2811 transmitter handshake.
// The sequencer takes the master modport; its environment takes the slave modport.
interface ws2811_frame_sequencer_if #(
  parameter int PW = 2,
  parameter int CW = 7
);
  logic                 frameTickIN;
  logic                 cmdValidIN;
  logic [31:0]          cmdIN;
  logic [23:0]          romDataIN;
  logic                 busyIN;
  logic [PW+CW-1:0]     romAddressOUT;
  logic                 txStartOUT;
  logic [23:0]          txDataOUT;
  logic                 frameActiveOUT;
  logic [PW-1:0]        patternIndexOUT;
  logic [7:0]           framesDroppedOUT;

  modport master (
    input  frameTickIN, cmdValidIN, cmdIN, romDataIN, busyIN,
    output romAddressOUT, txStartOUT, txDataOUT, frameActiveOUT, patternIndexOUT, framesDroppedOUT
  );

  modport slave (
    output frameTickIN, cmdValidIN, cmdIN, romDataIN, busyIN,
    input  romAddressOUT, txStartOUT, txDataOUT, frameActiveOUT, patternIndexOUT, framesDroppedOUT
  );
endinterface

// File: rtl/ws2811_frame_sequencer.sv
// Per frame tick: fetch one ROM colour per unit, hand it to the WS2811 transmitter, then hold the latch gap.
// Brightness scaling is compiled in only when WS2811_BRIGHTNESS_EN is defined.
module ws2811_frame_sequencer #(
  parameter int UNITS_NUMBER          = 100,
  parameter int PATTERN_COLORS_NUMBER = 128,
  parameter int PATTERNS_NUMBER       = 4,
  parameter int CLOCK_SPEED           = 50_000_000,
  parameter int LATCH_US              = 60
) (
  input logic                      clkIN,
  input logic                      nResetIN,
  ws2811_frame_sequencer_if.master bus
);
  localparam int PW           = $clog2(PATTERNS_NUMBER);
  localparam int CW           = $clog2(PATTERN_COLORS_NUMBER);
  localparam int UW           = $clog2(UNITS_NUMBER + 1);
  localparam int LATCH_CYCLES = CLOCK_SPEED / 1_000_000 * LATCH_US;
  localparam int LW           = $clog2(LATCH_CYCLES + 1);

  localparam logic [31:0] CMD_PAT_UP = 32'h00ff02fd;
  localparam logic [31:0] CMD_PAT_DN = 32'h00ff22dd;
`ifdef WS2811_BRIGHTNESS_EN
  localparam logic [31:0] CMD_BR_UP  = 32'h00ffa857;
  localparam logic [31:0] CMD_BR_DN  = 32'h00ffe01f;

  logic [2:0] level_q, level_d;

  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [2:0] lvl);
    logic [11:0] prod;
    prod = 12'(ch) * (12'(lvl) + 12'd1);
    return 8'(prod >> 3);
  endfunction
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_ROM, S_SEND, S_WAIT_BUSY, S_LATCH
  } state_t;

  state_t           state_q, state_d;
  logic [UW-1:0]    unit_q, unit_d;
  logic [CW-1:0]    color_q, color_d;
  logic [CW-1:0]    shift_q, shift_d;
  logic [PW-1:0]    pattern_q, pattern_d;
  logic             pend_vld_q, pend_vld_d;
  logic [31:0]      pend_cmd_q, pend_cmd_d;
  logic [PW+CW-1:0] rom_addr_q, rom_addr_d;
  logic             tx_start_q, tx_start_d;
  logic [23:0]      tx_dat_q, tx_dat_d;
  logic             frame_active_q, frame_active_d;
  logic [7:0]       dropped_q, dropped_d;
  logic             drain_q, drain_d;
  logic [LW-1:0]    latch_cnt_q, latch_cnt_d;

  always_comb begin
    state_d        = state_q;
    unit_d         = unit_q;
    color_d        = color_q;
    shift_d        = shift_q;
    pattern_d      = pattern_q;
    pend_vld_d     = pend_vld_q;
    pend_cmd_d     = pend_cmd_q;
    rom_addr_d     = rom_addr_q;
    tx_start_d     = 1'b0;
    tx_dat_d       = tx_dat_q;
    frame_active_d = frame_active_q;
    dropped_d      = dropped_q;
    drain_d        = drain_q;
    latch_cnt_d    = latch_cnt_q;
`ifdef WS2811_BRIGHTNESS_EN
    level_d        = level_q;
`endif

    // A command arriving with the accepting tick is visible to that frame via pend_*_d.
    if (bus.cmdValidIN) begin
      pend_vld_d = 1'b1;
      pend_cmd_d = bus.cmdIN;
    end

    if (bus.frameTickIN && (state_q != S_IDLE) && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.frameTickIN) begin
          state_d        = S_FETCH;
          frame_active_d = 1'b1;
          unit_d         = '0;
          color_d        = '0;
          shift_d        = shift_q + CW'(1);
          if (pend_vld_d) begin
            case (pend_cmd_d)
              CMD_PAT_UP: pattern_d = pattern_q + PW'(1);
              CMD_PAT_DN: pattern_d = pattern_q - PW'(1);
`ifdef WS2811_BRIGHTNESS_EN
              CMD_BR_UP:  if (level_q != 3'd7) level_d = level_q + 3'd1;
              CMD_BR_DN:  if (level_q != 3'd0) level_d = level_q - 3'd1;
`endif
              default: ;
            endcase
          end
          pend_vld_d = 1'b0;
          rom_addr_d = {pattern_d, shift_d};
        end
      end
      S_FETCH: state_d = S_WAIT_ROM;
      S_WAIT_ROM: begin
`ifdef WS2811_BRIGHTNESS_EN
        tx_dat_d = {scale_ch(bus.romDataIN[23:16], level_q),
                    scale_ch(bus.romDataIN[15:8],  level_q),
                    scale_ch(bus.romDataIN[7:0],   level_q)};
`else
        tx_dat_d = bus.romDataIN;
`endif
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!bus.busyIN) begin
          tx_start_d = 1'b1;
          unit_d     = unit_q + UW'(1);
          color_d    = color_q + CW'(1);
          drain_d    = 1'b0;
          state_d    = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        // Prefetch the next colour as soon as the transmitter takes the current one.
        if (!drain_q) begin
          if (bus.busyIN) begin
            if (unit_q == UW'(UNITS_NUMBER)) begin
              drain_d = 1'b1;
            end else begin
              state_d    = S_FETCH;
              rom_addr_d = {pattern_q, color_q + shift_q};
            end
          end
        end else if (!bus.busyIN) begin
          drain_d     = 1'b0;
          latch_cnt_d = LW'(1);
          state_d     = S_LATCH;
        end
      end
      S_LATCH: begin
        // The cycle that observed busy low already counts toward the gap.
        if (latch_cnt_q >= LW'(LATCH_CYCLES - 1)) begin
          state_d        = S_IDLE;
          frame_active_d = 1'b0;
        end else begin
          latch_cnt_d = latch_cnt_q + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state_q        <= S_IDLE;
      unit_q         <= '0;
      color_q        <= '0;
      shift_q        <= '0;
      pattern_q      <= '0;
      pend_vld_q     <= 1'b0;
      pend_cmd_q     <= '0;
      rom_addr_q     <= '0;
      tx_start_q     <= 1'b0;
      tx_dat_q       <= '0;
      frame_active_q <= 1'b0;
      dropped_q      <= '0;
      drain_q        <= 1'b0;
      latch_cnt_q    <= '0;
`ifdef WS2811_BRIGHTNESS_EN
      level_q        <= 3'd7;
`endif
    end else begin
      state_q        <= state_d;
      unit_q         <= unit_d;
      color_q        <= color_d;
      shift_q        <= shift_d;
      pattern_q      <= pattern_d;
      pend_vld_q     <= pend_vld_d;
      pend_cmd_q     <= pend_cmd_d;
      rom_addr_q     <= rom_addr_d;
      tx_start_q     <= tx_start_d;
      tx_dat_q       <= tx_dat_d;
      frame_active_q <= frame_active_d;
      dropped_q      <= dropped_d;
      drain_q        <= drain_d;
      latch_cnt_q    <= latch_cnt_d;
`ifdef WS2811_BRIGHTNESS_EN
      level_q        <= level_d;
`endif
    end
  end

  assign bus.romAddressOUT    = rom_addr_q;
  assign bus.txStartOUT       = tx_start_q;
  assign bus.txDataOUT        = tx_dat_q;
  assign bus.frameActiveOUT   = frame_active_q;
  assign bus.patternIndexOUT  = pattern_q;
  assign bus.framesDroppedOUT = dropped_q;

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Randomized bench for ws2811_frame_sequencer: ROM and transmitter models plus a frame-level reference model.
module tb_ws2811_frame_sequencer;
  localparam int UNITS  = 100;
  localparam int COLORS = 64;
  localparam int PATS   = 4;
  localparam int PW     = 2;
  localparam int CW     = 6;
  localparam int LC     = 3000;

  localparam logic [31:0] CMD_UP    = 32'h00ff02fd;
  localparam logic [31:0] CMD_DN    = 32'h00ff22dd;
  localparam logic [31:0] CMD_BR_UP = 32'h00ffa857;
  localparam logic [31:0] CMD_BR_DN = 32'h00ffe01f;

  logic clkIN = 1'b0;
  logic nResetIN;
  always #5 clkIN = ~clkIN;

  ws2811_frame_sequencer_if #(.PW(PW), .CW(CW)) bus ();

  ws2811_frame_sequencer #(
    .UNITS_NUMBER(UNITS), .PATTERN_COLORS_NUMBER(COLORS), .PATTERNS_NUMBER(PATS),
    .CLOCK_SPEED(50_000_000), .LATCH_US(60)
  ) dut (
    .clkIN(clkIN), .nResetIN(nResetIN), .bus(bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  logic [23:0] rom [0:PATS*COLORS-1];
  logic [23:0] exp_q [$];
  logic [23:0] prev_tx = '0;
  int cyc = 0, start_cnt = 0, first_start_cyc = 0, first_addr = 0;
  int fall_cyc = 0, tick_cyc = 0, busy_cnt = 0, rom_addr_prev = 0;
  bit start_seen = 1'b0;

  // Reference model state: frame-level view only.
  int m_shift = 0, m_pat = 0, m_dropped = 0, exp_addr0 = 0;
  bit m_pend = 1'b0;
  logic [31:0] m_cmd = '0;
`ifdef WS2811_BRIGHTNESS_EN
  int m_lvl = 7;
`endif

  function automatic logic [23:0] bright(input logic [23:0] c);
`ifdef WS2811_BRIGHTNESS_EN
    int r, g, b;
    r = (int'(c[23:16]) * (m_lvl + 1)) / 8;
    g = (int'(c[15:8])  * (m_lvl + 1)) / 8;
    b = (int'(c[7:0])   * (m_lvl + 1)) / 8;
    return {r[7:0], g[7:0], b[7:0]};
`else
    return c;
`endif
  endfunction

  function automatic logic [31:0] pick_cmd();
    case ($urandom_range(0, 4))
      0: return CMD_UP;
      1: return CMD_DN;
      2: return CMD_BR_UP;
      3: return CMD_BR_DN;
      default: return 32'($urandom);
    endcase
  endfunction

  // One clock: advance to just after the edge, then run ROM, transmitter and start monitors.
  task automatic step();
    @(posedge clkIN);
    #1;
    cyc++;
    bus.romDataIN = rom[rom_addr_prev];
    rom_addr_prev = int'(bus.romAddressOUT);
    if (bus.txStartOUT) begin
      chk("start_vs_busy", 32'(bus.busyIN), 32'd0);
      chk("tx_setup", 32'(prev_tx), 32'(bus.txDataOUT));
      if (exp_q.size() > 0) chk("tx_data", 32'(bus.txDataOUT), 32'(exp_q.pop_front()));
      if (start_cnt == 0) begin
        first_start_cyc = cyc;
        first_addr      = int'(bus.romAddressOUT);
      end
      start_cnt++;
    end
    prev_tx = bus.txDataOUT;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        bus.busyIN = 1'b0;
        fall_cyc   = cyc;
      end
    end
    if (start_seen) begin
      bus.busyIN = 1'b1;
      busy_cnt   = $urandom_range(6, 16);
    end
    start_seen = bus.txStartOUT;
    if (!nResetIN) begin
      bus.busyIN = 1'b0;
      busy_cnt   = 0;
      start_seen = 1'b0;
    end
  endtask

  task automatic model_frame();
    m_shift = (m_shift + 1) % COLORS;
    if (m_pend) begin
      if (m_cmd == CMD_UP) m_pat = (m_pat + 1) % PATS;
      else if (m_cmd == CMD_DN) m_pat = (m_pat + PATS - 1) % PATS;
`ifdef WS2811_BRIGHTNESS_EN
      else if (m_cmd == CMD_BR_UP && m_lvl < 7) m_lvl++;
      else if (m_cmd == CMD_BR_DN && m_lvl > 0) m_lvl--;
`endif
    end
    m_pend    = 1'b0;
    exp_addr0 = m_pat * COLORS + m_shift;
    exp_q.delete();
    for (int u = 0; u < UNITS; u++)
      exp_q.push_back(bright(rom[m_pat * COLORS + (u + m_shift) % COLORS]));
  endtask

  task automatic send_cmd(input logic [31:0] c);
    bus.cmdValidIN = 1'b1;
    bus.cmdIN      = c;
    step();
    bus.cmdValidIN = 1'b0;
    m_pend = 1'b1;
    m_cmd  = c;
  endtask

  task automatic accept_frame(input bit with_cmd, input logic [31:0] c);
    if (with_cmd) begin
      m_pend = 1'b1;
      m_cmd  = c;
      bus.cmdValidIN = 1'b1;
      bus.cmdIN      = c;
    end
    model_frame();
    start_cnt = 0;
    bus.frameTickIN = 1'b1;
    step();
    tick_cyc = cyc;
    bus.frameTickIN = 1'b0;
    bus.cmdValidIN  = 1'b0;
    chk("frame_active_rise", 32'(bus.frameActiveOUT), 32'd1);
    chk("pattern_index", 32'(bus.patternIndexOUT), 32'(m_pat));
  endtask

  task automatic drop_tick();
    bus.frameTickIN = 1'b1;
    step();
    bus.frameTickIN = 1'b0;
    if (m_dropped < 255) m_dropped++;
    step();
  endtask

  task automatic wait_starts(input int n);
    int budget = 5000;
    while (start_cnt < n && budget > 0) begin
      step();
      budget--;
    end
    chk("wait_starts", 32'(start_cnt >= n), 32'd1);
  endtask

  task automatic finish_frame();
    int budget = 20000;
    while (bus.frameActiveOUT && budget > 0) begin
      step();
      budget--;
    end
    chk("frame_end", 32'(bus.frameActiveOUT), 32'd0);
    chk("latch_gap", 32'(cyc - fall_cyc), 32'(LC));
    chk("start_count", 32'(start_cnt), 32'(UNITS));
    chk("tick_to_start", 32'(first_start_cyc - tick_cyc), 32'd3);
    chk("unit0_addr", 32'(first_addr), 32'(exp_addr0));
    chk("frames_dropped", 32'(bus.framesDroppedOUT), 32'(m_dropped));
  endtask

  task automatic check_reset_outputs();
    chk("rst_rom_addr", 32'(bus.romAddressOUT), 32'd0);
    chk("rst_tx_start", 32'(bus.txStartOUT), 32'd0);
    chk("rst_tx_data", 32'(bus.txDataOUT), 32'd0);
    chk("rst_frame_active", 32'(bus.frameActiveOUT), 32'd0);
    chk("rst_pattern", 32'(bus.patternIndexOUT), 32'd0);
    chk("rst_dropped", 32'(bus.framesDroppedOUT), 32'd0);
  endtask

  initial begin
    nResetIN        = 1'b0;
    bus.frameTickIN = 1'b0;
    bus.cmdValidIN  = 1'b0;
    bus.cmdIN       = '0;
    bus.romDataIN   = '0;
    bus.busyIN      = 1'b0;
    for (int i = 0; i < PATS * COLORS; i++) rom[i] = 24'($urandom);

    repeat (3) step();
    check_reset_outputs();
    nResetIN = 1'b1;
    repeat (2) step();

    // Two plain frames: unit-0 address follows the shift (1, then 2).
    accept_frame(1'b0, '0);
    finish_frame();
    accept_frame(1'b0, '0);
    wait_starts(2);
    drop_tick();
    chk("dropped_first", 32'(bus.framesDroppedOUT), 32'd1);
    send_cmd(CMD_DN);
    for (int k = 0; k < 299; k++) drop_tick();
    chk("dropped_sat", 32'(bus.framesDroppedOUT), 32'd255);
    chk("pattern_held", 32'(bus.patternIndexOUT), 32'd0);
    finish_frame();

    // Pattern-down command takes effect on the following frame: pattern 3.
    accept_frame(1'b0, '0);
    chk("pattern_wrap_down", 32'(bus.romAddressOUT >> CW), 32'd3);
    finish_frame();

    for (int f = 0; f < 3; f++) begin
      int ncmd = $urandom_range(0, 2);
      for (int k = 0; k < ncmd; k++) send_cmd(pick_cmd());
      accept_frame($urandom_range(0, 1) == 1, pick_cmd());
      if ($urandom_range(0, 1) == 1) begin
        wait_starts($urandom_range(1, 50));
        send_cmd(pick_cmd());
      end
      finish_frame();
    end

    // Reset while the sequencer waits for busy after a start.
    accept_frame(1'b0, '0);
    wait_starts(5);
    nResetIN = 1'b0;
    #1;
    check_reset_outputs();
    m_shift = 0; m_pat = 0; m_pend = 1'b0; m_dropped = 0;
`ifdef WS2811_BRIGHTNESS_EN
    m_lvl = 7;
`endif
    exp_q.delete();
    repeat (3) step();
    nResetIN = 1'b1;
    step();
    accept_frame(1'b0, '0);
    finish_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
